icb_dma_master: RTL
===================

ICB_DMA_MASTER -- requirements
Module: icb_dma_master

Interface
REQ-001 Parameter: LEN_W, 16, width of the transfer length and word counter.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  transfer request; sampled only in IDLE.
REQ-005 src_addr  input  32  source byte address; word-aligned.
REQ-006 dst_addr  input  32  destination byte address; word-aligned.
REQ-007 len  input  LEN_W  number of 32-bit words to copy.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 err  output  1  sticky error flag; cleared by the next accepted start.
REQ-011 words_done  output  LEN_W  count of words fully copied in the current or last transfer.
REQ-012 icb_cmd_valid  output  1  ICB command valid.
REQ-013 icb_cmd_ready  input  1  ICB command ready.
REQ-014 icb_cmd_read  output  1  1 = read, 0 = write.
REQ-015 icb_cmd_addr  output  32  command byte address.
REQ-016 icb_cmd_wdata  output  32  write data.
REQ-017 icb_cmd_wmask  output  4  byte mask; 4'hF on writes, 4'h0 on reads.
REQ-018 icb_rsp_valid  input  1  ICB response valid.
REQ-019 icb_rsp_ready  output  1  ICB response ready.
REQ-020 icb_rsp_rdata  input  32  read response data.
REQ-021 icb_rsp_err  input  1  response error.

Function
REQ-022 States SHALL be IDLE, RD_CMD, RD_RSP, WR_CMD, WR_RSP, DONE; one outstanding ICB transaction at most.
REQ-023 IDLE with start=1 SHALL latch src_addr, dst_addr, len, clear err and words_done, and go to RD_CMD, or to DONE if len==0.
REQ-024 start SHALL be ignored in every state other than IDLE.
REQ-025 RD_CMD: icb_cmd_valid=1, icb_cmd_read=1, icb_cmd_addr=src pointer; on valid&ready -> RD_RSP.
REQ-026 WR_CMD: icb_cmd_valid=1, icb_cmd_read=0, icb_cmd_addr=dst pointer, icb_cmd_wdata=captured read data, wmask=4'hF; on valid&ready -> WR_RSP.
REQ-027 While icb_cmd_valid=1 and icb_cmd_ready=0, all icb_cmd_* outputs SHALL hold stable; valid SHALL NOT drop before handshake.
REQ-028 icb_cmd_valid SHALL be 0 in IDLE, RD_RSP, WR_RSP, DONE.
REQ-029 icb_rsp_ready SHALL be 1 exactly in RD_RSP and WR_RSP; responses in other states SHALL be ignored.
REQ-030 RD_RSP on rsp_valid: err=0 -> capture icb_rsp_rdata, go WR_CMD; err=1 -> set err, go DONE.
REQ-031 WR_RSP on rsp_valid: err=1 -> set err, go DONE; else words_done+1, both pointers +4, then DONE if new words_done==len, otherwise RD_CMD.
REQ-032 Pointer increment SHALL wrap modulo 2^32; no boundary check.
REQ-033 Earliest response is the cycle after the command handshake; minimum per-word latency SHALL be 4 cycles (RD_CMD, RD_RSP, WR_CMD, WR_RSP) with zero-wait slave.
REQ-034 DONE SHALL assert done=1 for exactly one cycle and return to IDLE; busy=1 in DONE.
REQ-035 On error, words_done SHALL hold the count of words completed before the failing response.

Reset
REQ-036 rst=1 SHALL, on the next clock edge, force state IDLE and busy, done, err, words_done, icb_cmd_valid, icb_cmd_read, icb_cmd_addr, icb_cmd_wdata, icb_cmd_wmask, icb_rsp_ready to 0, including mid-transfer; a pending transaction is abandoned.

Verification
REQ-037 start, src=0x1000, dst=0x2000, len=3, zero-wait slave -> reads 0x1000/4/8, writes 0x2000/4/8 with read data, done pulse 12 cycles after RD_CMD entry, words_done=3, err=0.
REQ-038 start, len=0 -> no ICB command, busy for 1 cycle (DONE), done pulse, words_done=0.
REQ-039 cmd_ready held low 5 cycles on the 2nd write -> cmd_valid, addr=0x2004, wdata, wmask=4'hF stable all 5 cycles; transfer completes correctly.
REQ-040 rsp_err=1 on 2nd read of len=4 -> no 2nd write issued, err=1, words_done=1, done pulse; next start clears err.
REQ-041 src=0xFFFFFFFC, len=2 -> second read at 0x00000000.
REQ-042 rst=1 while in WR_CMD, then start again with len=1 -> cmd_valid=0 the cycle after reset edge, new transfer completes normally, start during busy ignored.

Source files
------------

// File: rtl/icb_dma_master.sv
// icb_dma_master: word-by-word memory copy over an ICB master port.
// Each word is a read command/response followed by a write command/response,
// with at most one ICB transaction outstanding at any time.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start; ICB port quiet
// S_RD_CMD | read command presented at the source pointer
// S_RD_RSP | waiting for the read response; data captured on success
// S_WR_CMD | write command presented at the destination pointer
// S_WR_RSP | waiting for the write response; counter and pointers advance
// S_DONE   | one-cycle completion pulse, then back to idle
module icb_dma_master #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [LEN_W-1:0] words_done,
  output logic             icb_cmd_valid,
  input  logic             icb_cmd_ready,
  output logic             icb_cmd_read,
  output logic [31:0]      icb_cmd_addr,
  output logic [31:0]      icb_cmd_wdata,
  output logic [3:0]       icb_cmd_wmask,
  input  logic             icb_rsp_valid,
  output logic             icb_rsp_ready,
  input  logic [31:0]      icb_rsp_rdata,
  input  logic             icb_rsp_err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD_CMD = 3'd1,
    S_RD_RSP = 3'd2,
    S_WR_CMD = 3'd3,
    S_WR_RSP = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      src_ptr, dst_ptr, rdata_q;
  logic [LEN_W-1:0] len_q, words_q, words_inc;
  logic             err_q;
  logic             cmd_hs;

  // Command outputs are decoded from state and registers only, so they cannot
  // change while a command is stalled waiting for ready.
  assign cmd_hs     = icb_cmd_valid & icb_cmd_ready;
  assign words_inc  = words_q + {{(LEN_W-1){1'b0}}, 1'b1};
  assign err        = err_q;
  assign words_done = words_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Transfer context: pointers, length, captured read data, progress and error
  always_ff @(posedge clk) begin
    if (rst) begin
      src_ptr <= '0;
      dst_ptr <= '0;
      rdata_q <= '0;
      len_q   <= '0;
      words_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            src_ptr <= src_addr;
            dst_ptr <= dst_addr;
            len_q   <= len;
            words_q <= '0;
            err_q   <= 1'b0;
          end
        end
        S_RD_RSP: begin
          if (icb_rsp_valid) begin
            if (icb_rsp_err) err_q   <= 1'b1;
            else             rdata_q <= icb_rsp_rdata;
          end
        end
        S_WR_RSP: begin
          if (icb_rsp_valid) begin
            if (icb_rsp_err) begin
              err_q <= 1'b1;
            end else begin
              words_q <= words_inc;
              src_ptr <= src_ptr + 32'd4;
              dst_ptr <= dst_ptr + 32'd4;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = (len == '0) ? S_DONE : S_RD_CMD;
      S_RD_CMD: if (cmd_hs) state_d = S_RD_RSP;
      S_RD_RSP: if (icb_rsp_valid) state_d = icb_rsp_err ? S_DONE : S_WR_CMD;
      S_WR_CMD: if (cmd_hs) state_d = S_WR_RSP;
      S_WR_RSP: begin
        if (icb_rsp_valid) begin
          if (icb_rsp_err || (words_inc == len_q)) state_d = S_DONE;
          else                                      state_d = S_RD_CMD;
        end
      end
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy          = (state_q != S_IDLE);
    done          = 1'b0;
    icb_cmd_valid = 1'b0;
    icb_cmd_read  = 1'b0;
    icb_cmd_addr  = '0;
    icb_cmd_wdata = '0;
    icb_cmd_wmask = 4'h0;
    icb_rsp_ready = 1'b0;
    case (state_q)
      S_RD_CMD: begin
        icb_cmd_valid = 1'b1;
        icb_cmd_read  = 1'b1;
        icb_cmd_addr  = src_ptr;
      end
      S_WR_CMD: begin
        icb_cmd_valid = 1'b1;
        icb_cmd_addr  = dst_ptr;
        icb_cmd_wdata = rdata_q;
        icb_cmd_wmask = 4'hF;
      end
      S_RD_RSP, S_WR_RSP: icb_rsp_ready = 1'b1;
      S_DONE:             done          = 1'b1;
      default: ;
    endcase
  end

endmodule
